xge_tx_sched: RTL and testbench

- Packet-granular round-robin arbiter that shares the single MAC transmit packet interface (pkt_tx_*) between NUM_REQ independent packet sources in the clk_156m25 domain.
- Locks the grant for a whole packet (sop..eop) and stalls on pkt_tx_full.
- Enforces a maximum packet length: an overlong packet is truncated and the rest is drained.
- Sits between the host-side packet sources and the MAC pkt_tx port.

---
 rtl/xge_tx_sched_if.sv | 28 ++
 rtl/xge_tx_sched.sv | 171 +++++++++++++++++
 tb/tb_xge_tx_sched.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xge_tx_sched_if.sv
// Bundles the per-requester packet sources and the MAC pkt_tx port.
// master = the surrounding system (sources and MAC), slave = the scheduler.
interface xge_tx_sched_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_val;
    logic [NUM_REQ-1:0]    req_sop;
    logic [NUM_REQ-1:0]    req_eop;
    logic [3*NUM_REQ-1:0]  req_mod;
    logic [64*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  pkt_tx_full;
    logic                  pkt_tx_val;
    logic                  pkt_tx_sop;
    logic                  pkt_tx_eop;
    logic [2:0]            pkt_tx_mod;
    logic [63:0]           pkt_tx_data;

    modport master (
        output req_val, req_sop, req_eop, req_mod, req_data, pkt_tx_full,
        input  req_ready, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data
    );

    modport slave (
        input  req_val, req_sop, req_eop, req_mod, req_data, pkt_tx_full,
        output req_ready, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data
    );
endinterface

// File: rtl/xge_tx_sched.sv
// Packet-granular round-robin arbiter feeding the MAC pkt_tx port.
// Grants are locked sop..eop; packets longer than MAX_WORDS are cut and drained.
module xge_tx_sched #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_WORDS = 1200
) (
    input  logic              clk_156m25,
    input  logic              reset_156m25,
    xge_tx_sched_if.slave     bus,
    output logic [2:0]        grant_id,
    output logic              busy,
    output logic              trunc_err,
    output logic [31:0]       pkt_cnt
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEND  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam int         CW       = $clog2(MAX_WORDS + 1);

    logic [1:0]         r_state;
    logic [2:0]         r_grant;
    logic [2:0]         r_ptr;
    logic [CW-1:0]      r_wcnt;
    logic               r_tx_val;
    logic               r_tx_sop;
    logic               r_tx_eop;
    logic [2:0]         r_tx_mod;
    logic [63:0]        r_tx_data;
    logic               r_trunc;
    logic [31:0]        r_pkt_cnt;

    logic [NUM_REQ-1:0] w_cand;
    logic [3:0]         w_pos;
    logic               w_found;
    logic [2:0]         w_sel;
    logic               w_g_val;
    logic               w_g_sop;
    logic               w_g_eop;
    logic [2:0]         w_g_mod;
    logic [63:0]        w_g_data;
    logic               w_acc_send;
    logic               w_acc_drain;
    logic [2:0]         w_ptr_next;

    // Beat fields of the currently granted requester.
    always_comb begin
        w_g_val  = 1'b0;
        w_g_sop  = 1'b0;
        w_g_eop  = 1'b0;
        w_g_mod  = 3'd0;
        w_g_data = 64'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r_grant == 3'(k)) begin
                w_g_val  = bus.req_val[k];
                w_g_sop  = bus.req_sop[k];
                w_g_eop  = bus.req_eop[k];
                w_g_mod  = bus.req_mod[3*k +: 3];
                w_g_data = bus.req_data[64*k +: 64];
            end
        end
    end

    // First sop candidate at or after the pointer, wrapping around.
    always_comb begin
        w_cand  = bus.req_val & bus.req_sop;
        w_found = 1'b0;
        w_sel   = r_ptr;
        w_pos   = 4'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = {1'b0, r_ptr} + 4'(k);
            if (w_pos >= 4'(NUM_REQ)) begin
                w_pos = w_pos - 4'(NUM_REQ);
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!w_found && w_cand[j] && (w_pos == 4'(j))) begin
                    w_found = 1'b1;
                    w_sel   = 3'(j);
                end
            end
        end
    end

    // Draining ignores the MAC full flag since nothing is forwarded.
    always_comb begin
        bus.req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r_grant == 3'(k)) begin
                if (r_state == ST_SEND) begin
                    bus.req_ready[k] = ~bus.pkt_tx_full;
                end else if (r_state == ST_DRAIN) begin
                    bus.req_ready[k] = 1'b1;
                end
            end
        end
    end

    assign w_acc_send  = (r_state == ST_SEND) && w_g_val && !bus.pkt_tx_full;
    assign w_acc_drain = (r_state == ST_DRAIN) && w_g_val;
    assign w_ptr_next  = (r_grant == 3'(NUM_REQ - 1)) ? 3'd0 : r_grant + 3'd1;

    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            r_state   <= ST_IDLE;
            r_grant   <= 3'd0;
            r_ptr     <= 3'd0;
            r_wcnt    <= '0;
            r_tx_val  <= 1'b0;
            r_tx_sop  <= 1'b0;
            r_tx_eop  <= 1'b0;
            r_tx_mod  <= 3'd0;
            r_tx_data <= 64'd0;
            r_trunc   <= 1'b0;
            r_pkt_cnt <= 32'd0;
        end else begin
            r_tx_val <= 1'b0;
            r_tx_sop <= 1'b0;
            r_tx_eop <= 1'b0;
            r_trunc  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_sel;
                        r_wcnt  <= '0;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_acc_send) begin
                        r_tx_val  <= 1'b1;
                        r_tx_sop  <= w_g_sop;
                        r_tx_data <= w_g_data;
                        r_wcnt    <= r_wcnt + CW'(1);
                        // A real eop on the last allowed word wins over truncation.
                        if (w_g_eop) begin
                            r_tx_eop  <= 1'b1;
                            r_tx_mod  <= w_g_mod;
                            r_pkt_cnt <= r_pkt_cnt + 32'd1;
                            r_ptr     <= w_ptr_next;
                            r_state   <= ST_IDLE;
                        end else if (r_wcnt == CW'(MAX_WORDS - 1)) begin
                            r_tx_eop  <= 1'b1;
                            r_tx_mod  <= 3'd0;
                            r_trunc   <= 1'b1;
                            r_pkt_cnt <= r_pkt_cnt + 32'd1;
                            r_ptr     <= w_ptr_next;
                            r_state   <= ST_DRAIN;
                        end else begin
                            r_tx_mod <= w_g_mod;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_acc_drain && w_g_eop) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.pkt_tx_val  = r_tx_val;
    assign bus.pkt_tx_sop  = r_tx_sop;
    assign bus.pkt_tx_eop  = r_tx_eop;
    assign bus.pkt_tx_mod  = r_tx_mod;
    assign bus.pkt_tx_data = r_tx_data;
    assign grant_id        = r_grant;
    assign busy            = (r_state != ST_IDLE);
    assign trunc_err       = r_trunc;
    assign pkt_cnt         = r_pkt_cnt;
endmodule

// File: tb/tb_xge_tx_sched.sv
// Directed bench for xge_tx_sched with NUM_REQ=4 and MAX_WORDS=4.
module tb_xge_tx_sched;
    logic        clk_156m25 = 1'b0;
    logic        reset_156m25;
    logic [2:0]  grant_id;
    logic        busy;
    logic        trunc_err;
    logic [31:0] pkt_cnt;

    int testCnt = 0;
    int failCnt = 0;

    xge_tx_sched_if #(.NUM_REQ(4)) bus ();

    xge_tx_sched #(.NUM_REQ(4), .MAX_WORDS(4)) dut (
        .clk_156m25   (clk_156m25),
        .reset_156m25 (reset_156m25),
        .bus          (bus.slave),
        .grant_id     (grant_id),
        .busy         (busy),
        .trunc_err    (trunc_err),
        .pkt_cnt      (pkt_cnt)
    );

    always #5 clk_156m25 = ~clk_156m25;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_156m25);
        #1;
    endtask

    task automatic applyStimulus(input int r, input logic v, input logic s, input logic e,
                                 input logic [2:0] m, input logic [63:0] d);
        bus.req_val[r]           = v;
        bus.req_sop[r]           = s;
        bus.req_eop[r]           = e;
        bus.req_mod[3*r +: 3]    = m;
        bus.req_data[64*r +: 64] = d;
    endtask

    task automatic clearAll();
        bus.req_val     = '0;
        bus.req_sop     = '0;
        bus.req_eop     = '0;
        bus.req_mod     = '0;
        bus.req_data    = '0;
        bus.pkt_tx_full = 1'b0;
    endtask

    function automatic logic [63:0] beatData(input int r, input int p, input int b);
        return 64'(r * 256 + p * 16 + b);
    endfunction

    initial begin
        logic [3:0] acc;
        int         p[4];
        int         b[4];
        int         nPkt;
        int         nOut;
        int         c;
        int         k;
        int         be;
        int         sent;
        int         truncCnt;
        logic       prevFull;
        logic       gotOut;

        // Reset values
        clearAll();
        reset_156m25 = 1'b1;
        tick();
        tick();
        checkOutput("rst_val", 64'(bus.pkt_tx_val), 64'(0));
        checkOutput("rst_sop", 64'(bus.pkt_tx_sop), 64'(0));
        checkOutput("rst_eop", 64'(bus.pkt_tx_eop), 64'(0));
        checkOutput("rst_mod", 64'(bus.pkt_tx_mod), 64'(0));
        checkOutput("rst_data", bus.pkt_tx_data, 64'(0));
        checkOutput("rst_ready", 64'(bus.req_ready), 64'(0));
        checkOutput("rst_grant", 64'(grant_id), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_trunc", 64'(trunc_err), 64'(0));
        checkOutput("rst_cnt", 64'(pkt_cnt), 64'(0));
        reset_156m25 = 1'b0;

        // Single source, three beats from requester 0
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 3'd0, 64'h1111111111111111);
        #1;
        checkOutput("t1_idle_ready", 64'(bus.req_ready), 64'(0));
        tick();
        checkOutput("t1_grant", 64'(grant_id), 64'(0));
        checkOutput("t1_ready", 64'(bus.req_ready), 64'(4'b0001));
        checkOutput("t1_busy", 64'(busy), 64'(1));
        checkOutput("t1_noval", 64'(bus.pkt_tx_val), 64'(0));
        tick();
        checkOutput("t1_b1_val", 64'(bus.pkt_tx_val), 64'(1));
        checkOutput("t1_b1_sop", 64'(bus.pkt_tx_sop), 64'(1));
        checkOutput("t1_b1_data", bus.pkt_tx_data, 64'h1111111111111111);
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 3'd0, 64'h2222222222222222);
        tick();
        checkOutput("t1_b2_val", 64'(bus.pkt_tx_val), 64'(1));
        checkOutput("t1_b2_sop", 64'(bus.pkt_tx_sop), 64'(0));
        checkOutput("t1_b2_eop", 64'(bus.pkt_tx_eop), 64'(0));
        checkOutput("t1_b2_data", bus.pkt_tx_data, 64'h2222222222222222);
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 3'd5, 64'h3333333333333333);
        tick();
        checkOutput("t1_b3_val", 64'(bus.pkt_tx_val), 64'(1));
        checkOutput("t1_b3_eop", 64'(bus.pkt_tx_eop), 64'(1));
        checkOutput("t1_b3_mod", 64'(bus.pkt_tx_mod), 64'(5));
        checkOutput("t1_b3_data", bus.pkt_tx_data, 64'h3333333333333333);
        checkOutput("t1_cnt", 64'(pkt_cnt), 64'(1));
        checkOutput("t1_idle", 64'(busy), 64'(0));
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
        tick();
        checkOutput("t1_val_drop", 64'(bus.pkt_tx_val), 64'(0));

        reset_156m25 = 1'b1;
        tick();
        reset_156m25 = 1'b0;

        // Fairness: four sources offering 2-beat packets back to back
        for (int r = 0; r < 4; r++) begin
            p[r] = 0;
            b[r] = 0;
            applyStimulus(r, 1'b1, 1'b1, 1'b0, 3'd0, beatData(r, 0, 0));
        end
        nPkt = 0;
        nOut = 0;
        c    = 0;
        while (nPkt < 5 && c < 60) begin
            #1;
            acc = bus.req_val & bus.req_ready;
            tick();
            c++;
            if (bus.pkt_tx_val) begin
                k  = nOut / 2;
                be = nOut % 2;
                checkOutput($sformatf("fair_data%0d", nOut), bus.pkt_tx_data, beatData(k % 4, k / 4, be));
                checkOutput($sformatf("fair_sop%0d", nOut), 64'(bus.pkt_tx_sop), 64'(be == 0));
                checkOutput($sformatf("fair_eop%0d", nOut), 64'(bus.pkt_tx_eop), 64'(be == 1));
                nOut++;
                if (bus.pkt_tx_eop) nPkt++;
            end
            for (int r = 0; r < 4; r++) begin
                if (acc[r]) begin
                    if (b[r] == 1) begin
                        b[r] = 0;
                        p[r] = p[r] + 1;
                    end else begin
                        b[r] = 1;
                    end
                    applyStimulus(r, 1'b1, b[r] == 0, b[r] == 1, 3'd0, beatData(r, p[r], b[r]));
                end
            end
            if (nPkt == 5) clearAll();
        end
        checkOutput("fair_pkts", 64'(nPkt), 64'(5));
        checkOutput("fair_cnt", 64'(pkt_cnt), 64'(5));
        clearAll();
        tick();
        checkOutput("fair_idle", 64'(busy), 64'(0));

        // Backpressure: MAC full for four cycles in the middle of a 4-word packet
        applyStimulus(3, 1'b1, 1'b1, 1'b0, 3'd0, 64'hB0);
        c        = 0;
        nOut     = 0;
        sent     = 0;
        prevFull = 1'b0;
        while (nOut < 4 && c < 40) begin
            bus.pkt_tx_full = (c >= 3 && c < 7);
            #1;
            if (bus.pkt_tx_full && busy) begin
                checkOutput($sformatf("bp_ready_low%0d", c), 64'(bus.req_ready), 64'(0));
            end
            acc      = bus.req_val & bus.req_ready;
            prevFull = bus.pkt_tx_full;
            tick();
            c++;
            if (prevFull) begin
                checkOutput($sformatf("bp_val_low%0d", c), 64'(bus.pkt_tx_val), 64'(0));
            end
            if (bus.pkt_tx_val) begin
                checkOutput($sformatf("bp_data%0d", nOut), bus.pkt_tx_data, 64'(8'hB0 + nOut));
                checkOutput($sformatf("bp_eop%0d", nOut), 64'(bus.pkt_tx_eop), 64'(nOut == 3));
                if (nOut == 3) checkOutput("bp_last_mod", 64'(bus.pkt_tx_mod), 64'(3));
                nOut++;
            end
            if (acc[3]) begin
                sent++;
                if (sent < 4) begin
                    applyStimulus(3, 1'b1, 1'b0, sent == 3, (sent == 3) ? 3'd3 : 3'd0, 64'(8'hB0 + sent));
                end else begin
                    applyStimulus(3, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
                end
            end
        end
        bus.pkt_tx_full = 1'b0;
        checkOutput("bp_count", 64'(nOut), 64'(4));
        checkOutput("bp_sent", 64'(sent), 64'(4));
        checkOutput("bp_cnt", 64'(pkt_cnt), 64'(6));
        checkOutput("bp_no_trunc", 64'(trunc_err), 64'(0));
        checkOutput("bp_idle", 64'(busy), 64'(0));

        // Truncation: 7-word packet from requester 1, only 4 words leave
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 3'd6, 64'hC0);
        c        = 0;
        nOut     = 0;
        sent     = 0;
        truncCnt = 0;
        while (sent < 7 && c < 40) begin
            #1;
            acc = bus.req_val & bus.req_ready;
            tick();
            c++;
            if (trunc_err) truncCnt++;
            if (bus.pkt_tx_val) begin
                checkOutput($sformatf("tr_data%0d", nOut), bus.pkt_tx_data, 64'(8'hC0 + nOut));
                if (nOut == 3) begin
                    checkOutput("tr_eop", 64'(bus.pkt_tx_eop), 64'(1));
                    checkOutput("tr_mod", 64'(bus.pkt_tx_mod), 64'(0));
                end else begin
                    checkOutput($sformatf("tr_noeop%0d", nOut), 64'(bus.pkt_tx_eop), 64'(0));
                end
                nOut++;
            end
            if (acc[1]) begin
                sent++;
                if (sent < 7) begin
                    applyStimulus(1, 1'b1, 1'b0, sent == 6, 3'd6, 64'(8'hC0 + sent));
                end else begin
                    applyStimulus(1, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
                end
            end
        end
        checkOutput("tr_sent", 64'(sent), 64'(7));
        checkOutput("tr_idle", 64'(busy), 64'(0));
        tick();
        if (trunc_err) truncCnt++;
        checkOutput("tr_out_count", 64'(nOut), 64'(4));
        checkOutput("tr_pulses", 64'(truncCnt), 64'(1));
        checkOutput("tr_val_after", 64'(bus.pkt_tx_val), 64'(0));
        checkOutput("tr_cnt", 64'(pkt_cnt), 64'(7));

        // Bad start: requester 2 valid without sop, requester 3 with sop
        applyStimulus(2, 1'b1, 1'b0, 1'b0, 3'd0, 64'hDEAD);
        applyStimulus(3, 1'b1, 1'b1, 1'b1, 3'd2, 64'hE0);
        c      = 0;
        gotOut = 1'b0;
        while (!gotOut && c < 10) begin
            #1;
            checkOutput($sformatf("bs_ready2_%0d", c), 64'(bus.req_ready[2]), 64'(0));
            acc = bus.req_val & bus.req_ready;
            tick();
            c++;
            if (bus.pkt_tx_val) begin
                gotOut = 1'b1;
                checkOutput("bs_data", bus.pkt_tx_data, 64'hE0);
                checkOutput("bs_sop_eop", 64'({bus.pkt_tx_sop, bus.pkt_tx_eop}), 64'(2'b11));
                checkOutput("bs_mod", 64'(bus.pkt_tx_mod), 64'(2));
                checkOutput("bs_grant", 64'(grant_id), 64'(3));
            end
            if (acc[3]) applyStimulus(3, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
        end
        checkOutput("bs_got", 64'(gotOut), 64'(1));
        checkOutput("bs_cnt", 64'(pkt_cnt), 64'(8));
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("bs_hold_ready%0d", i), 64'(bus.req_ready[2]), 64'(0));
            checkOutput($sformatf("bs_hold_busy%0d", i), 64'(busy), 64'(0));
        end
        clearAll();

        // Reset in the middle of a packet, then a clean packet
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 3'd0, 64'hF0);
        tick();
        checkOutput("rm_grant", 64'(grant_id), 64'(0));
        tick();
        checkOutput("rm_b1_data", bus.pkt_tx_data, 64'hF0);
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 3'd0, 64'hF1);
        reset_156m25 = 1'b1;
        tick();
        checkOutput("rm_val", 64'(bus.pkt_tx_val), 64'(0));
        checkOutput("rm_eop", 64'(bus.pkt_tx_eop), 64'(0));
        checkOutput("rm_data", bus.pkt_tx_data, 64'(0));
        checkOutput("rm_ready", 64'(bus.req_ready), 64'(0));
        checkOutput("rm_busy", 64'(busy), 64'(0));
        checkOutput("rm_cnt", 64'(pkt_cnt), 64'(0));
        reset_156m25 = 1'b0;
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 3'd0, 64'hA0);
        tick();
        checkOutput("rm_regrant_busy", 64'(busy), 64'(1));
        tick();
        checkOutput("rm_n1_val", 64'(bus.pkt_tx_val), 64'(1));
        checkOutput("rm_n1_data", bus.pkt_tx_data, 64'hA0);
        checkOutput("rm_n1_sop", 64'(bus.pkt_tx_sop), 64'(1));
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 3'd7, 64'hA1);
        tick();
        checkOutput("rm_n2_data", bus.pkt_tx_data, 64'hA1);
        checkOutput("rm_n2_eop", 64'(bus.pkt_tx_eop), 64'(1));
        checkOutput("rm_n2_mod", 64'(bus.pkt_tx_mod), 64'(7));
        checkOutput("rm_n2_cnt", 64'(pkt_cnt), 64'(1));
        clearAll();
        tick();
        checkOutput("rm_end_idle", 64'(busy), 64'(0));

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end
endmodule
